// File: rtl/servo_pkg.sv
// Shared servo definitions: move codes, sequencer state encoding and the default step/gap timing.
package servo_pkg;

   localparam int unsigned MOVE_W = 4;
   typedef logic [MOVE_W-1:0] move_t;

   // Face turns and their primes; END_CODE marks the end of a move list.
   localparam move_t MOVE_L   = 4'h0;
   localparam move_t MOVE_LP  = 4'h1;
   localparam move_t MOVE_R   = 4'h2;
   localparam move_t MOVE_RP  = 4'h3;
   localparam move_t MOVE_U   = 4'h4;
   localparam move_t MOVE_UP  = 4'h5;
   localparam move_t MOVE_D   = 4'h6;
   localparam move_t MOVE_DP  = 4'h7;
   localparam move_t MOVE_F   = 4'h8;
   localparam move_t MOVE_FP  = 4'h9;
   localparam move_t MOVE_B   = 4'hA;
   localparam move_t MOVE_BP  = 4'hB;
   localparam move_t END_CODE = 4'hF;

   typedef enum logic [2:0] {
      SEQ_IDLE  = 3'd0,
      SEQ_FETCH = 3'd1,
      SEQ_LATCH = 3'd2,
      SEQ_ISSUE = 3'd3,
      SEQ_GAP   = 3'd4,
      SEQ_DONE  = 3'd5
   } seq_state_e;

   // 1 s at 50 MHz; also the translator's step period.
   localparam int unsigned GAP_CYCLES_DEFAULT = 50_000_000;

endpackage

// File: rtl/gap_timer.sv
// Loadable down-counter: load wins over decrement, decrement stops at zero.
module gap_timer #(
   parameter int unsigned WIDTH = 26
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec,
   output logic [WIDTH-1:0] value,
   output logic             zero
);

   logic [WIDTH-1:0] value_q, value_d;
   logic             zero_q, zero_d;

   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = load_value;
      end else if (dec && (value_q != '0)) begin
         value_d = value_q - WIDTH'(1);
      end
      zero_d = (value_d == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value_q <= '0;
         zero_q  <= 1'b1;
      end else begin
         value_q <= value_d;
         zero_q  <= zero_d;
      end
   end

   assign value = value_q;
   assign zero  = zero_q;

endmodule

// File: rtl/move_sequencer.sv
// Walks the move list in dmem, hands each code to the translator and spaces moves by a settle gap.
module move_sequencer
   import servo_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 8,
   parameter int unsigned           MOVE_WIDTH = 4,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
   parameter logic [MOVE_WIDTH-1:0] END_CODE   = MOVE_WIDTH'(servo_pkg::END_CODE),
   parameter int unsigned           GAP_CYCLES = GAP_CYCLES_DEFAULT
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   input  logic [DATA_WIDTH-1:0] dmem_rdata,
   output logic [MOVE_WIDTH-1:0] move_code,
   output logic                  move_valid,
   input  logic                  move_done,
   output logic                  busy,
   output logic                  done,
   output logic                  overrun,
   output logic [ADDR_WIDTH:0]   move_count
);

   localparam int unsigned          GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0]     GAP_LOAD  = GAP_W'((GAP_CYCLES != 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [ADDR_WIDTH:0]  COUNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

   seq_state_e state_q, state_d;

   logic [ADDR_WIDTH-1:0] dmem_addr_q, dmem_addr_d;
   logic [MOVE_WIDTH-1:0] move_code_q, move_code_d;
   logic                  move_valid_q, move_valid_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  overrun_q, overrun_d;
   logic [ADDR_WIDTH:0]   move_count_q, move_count_d;

   logic [MOVE_WIDTH-1:0] rdata_code_c;
   logic                  unused_rdata_c;
   logic                  addr_last_c;
   logic                  gap_load_c;
   logic                  gap_dec_c;
   logic                  gap_zero;
   logic [GAP_W-1:0]      unused_gap_value;

   assign rdata_code_c   = dmem_rdata[MOVE_WIDTH-1:0];
   assign unused_rdata_c = ^dmem_rdata[DATA_WIDTH-1:MOVE_WIDTH];
   assign addr_last_c    = &dmem_addr_q;
   assign gap_dec_c      = (state_q == SEQ_GAP);

   gap_timer #(
      .WIDTH(GAP_W)
   ) u_gap_timer (
      .clk       (clk),
      .rst       (rst),
      .load      (gap_load_c),
      .load_value(GAP_LOAD),
      .dec       (gap_dec_c),
      .value     (unused_gap_value),
      .zero      (gap_zero)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= SEQ_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state; abort overrides everything, including a coincident move_done.
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = SEQ_IDLE;
      end else begin
         unique case (state_q)
            SEQ_IDLE, SEQ_DONE: if (start) state_d = SEQ_FETCH;
            SEQ_FETCH:          state_d = SEQ_LATCH;
            SEQ_LATCH:          state_d = (rdata_code_c == END_CODE) ? SEQ_DONE : SEQ_ISSUE;
            SEQ_ISSUE: begin
               if (move_done) begin
                  if (addr_last_c)          state_d = SEQ_DONE;
                  else if (GAP_CYCLES == 0) state_d = SEQ_FETCH;
                  else                      state_d = SEQ_GAP;
               end
            end
            SEQ_GAP:            if (gap_zero) state_d = SEQ_FETCH;
            default:            state_d = SEQ_IDLE;
         endcase
      end
   end

   // Output and datapath next values; everything holds unless a transition changes it.
   always_comb begin
      dmem_addr_d  = dmem_addr_q;
      move_code_d  = move_code_q;
      move_valid_d = move_valid_q;
      overrun_d    = overrun_q;
      move_count_d = move_count_q;
      gap_load_c   = 1'b0;
      busy_d       = state_d inside {SEQ_FETCH, SEQ_LATCH, SEQ_ISSUE, SEQ_GAP};
      done_d       = (state_d == SEQ_DONE);
      if (abort) begin
         move_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            SEQ_IDLE, SEQ_DONE: begin
               if (start) begin
                  dmem_addr_d  = START_ADDR;
                  move_count_d = '0;
                  overrun_d    = 1'b0;
               end
            end
            SEQ_LATCH: begin
               if (rdata_code_c != END_CODE) begin
                  move_code_d  = rdata_code_c;
                  move_valid_d = 1'b1;
               end
            end
            SEQ_ISSUE: begin
               if (move_done) begin
                  move_valid_d = 1'b0;
                  if (move_count_q != COUNT_MAX) begin
                     move_count_d = move_count_q + (ADDR_WIDTH+1)'(1);
                  end
                  // The list never wraps: the last address ends the sequence.
                  if (addr_last_c) begin
                     overrun_d = 1'b1;
                  end else begin
                     dmem_addr_d = dmem_addr_q + ADDR_WIDTH'(1);
                     gap_load_c  = (GAP_CYCLES != 0);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dmem_addr_q  <= START_ADDR;
         move_code_q  <= '0;
         move_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         overrun_q    <= 1'b0;
         move_count_q <= '0;
      end else begin
         dmem_addr_q  <= dmem_addr_d;
         move_code_q  <= move_code_d;
         move_valid_q <= move_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         overrun_q    <= overrun_d;
         move_count_q <= move_count_d;
      end
   end

   assign dmem_addr  = dmem_addr_q;
   assign move_code  = move_code_q;
   assign move_valid = move_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign overrun    = overrun_q;
   assign move_count = move_count_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: a list-walking reference model feeds expected moves and end states.
module tb_move_sequencer;

   localparam int unsigned     AW    = 2;
   localparam int unsigned     MW    = 4;
   localparam int unsigned     DW    = 32;
   localparam int unsigned     GAP   = 4;
   localparam logic [AW-1:0]   START = '0;
   localparam logic [MW-1:0]   ENDC  = 4'hF;

   typedef struct {
      int done_v;
      int ovr;
      int cnt;
      int addr;
      int rel;
   } end_rec_t;

   logic          clk = 1'b0;
   logic          rst, start, abort, move_done;
   logic [AW-1:0] dmem_addr;
   logic [DW-1:0] dmem_rdata;
   logic [MW-1:0] move_code;
   logic          move_valid, busy, done, overrun;
   logic [AW:0]   move_count;

   logic [DW-1:0] mem [1<<AW];

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int start_cyc = 0;
   int done_delay = -1;
   int abort_at = 0;
   int exp_q[$];
   end_rec_t end_q[$];

   move_sequencer #(
      .ADDR_WIDTH(AW), .MOVE_WIDTH(MW), .DATA_WIDTH(DW),
      .START_ADDR(START), .END_CODE(ENDC), .GAP_CYCLES(GAP)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
      .move_code(move_code), .move_valid(move_valid), .move_done(move_done),
      .busy(busy), .done(done), .overrun(overrun), .move_count(move_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) dmem_rdata <= mem[dmem_addr];

   task automatic chk(input string name, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " dmem_addr"},  int'(dmem_addr), int'(START));
      chk({tag, " move_code"},  int'(move_code), 0);
      chk({tag, " move_valid"}, int'(move_valid), 0);
      chk({tag, " busy"},       int'(busy), 0);
      chk({tag, " done"},       int'(done), 0);
      chk({tag, " overrun"},    int'(overrun), 0);
      chk({tag, " move_count"}, int'(move_count), 0);
   endtask

   // Reference: walk the list from START; stop on END_CODE, abort on move k, or the last address.
   task automatic push_model(input int k, input int rel);
      int a = int'(START);
      int n = 0;
      end_rec_t r;
      logic [DW-1:0] w;
      int code;
      forever begin
         w = mem[AW'(a)];
         code = int'(w[MW-1:0]);
         if (code == int'(ENDC)) begin r = '{1, 0, n, a, rel}; break; end
         exp_q.push_back(code);
         n++;
         if (n == k) begin r = '{0, 0, n - 1, a, rel}; break; end
         if (a == (1 << AW) - 1) begin r = '{1, 1, n, a, rel}; break; end
         a++;
      end
      end_q.push_back(r);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1;
      start = 1'b1;
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_seq(input int k, input int rel, input bit noise);
      int budget = 600;
      abort_at = k;
      push_model(k, rel);
      pulse_start();
      while (busy && budget > 0) begin
         if (noise && $urandom_range(0, 3) == 0) start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         budget--;
      end
      if (budget == 0) chk("sequence timeout", 1, 0);
      repeat (2) @(posedge clk);
   endtask

   // Translator stand-in: acknowledges each move after done_delay cycles, optionally with abort.
   initial begin : translator
      int d;
      int n_issued;
      move_done = 1'b0;
      abort = 1'b0;
      n_issued = 0;
      forever begin
         @(posedge clk); #1;
         move_done = 1'b0;
         abort = 1'b0;
         if (!busy) begin
            n_issued = 0;
         end else if (move_valid) begin
            n_issued++;
            d = (done_delay >= 0) ? done_delay : int'($urandom_range(0, 4));
            repeat (d) begin @(posedge clk); #1; end
            if (move_valid && rst) begin
               move_done = 1'b1;
               if (abort_at == n_issued) abort = 1'b1;
            end
         end
      end
   end

   // Monitor: checks each presented move and every end of sequence against the scoreboard.
   initial begin : monitor
      bit pv, pb, first;
      int low, e;
      end_rec_t r;
      pv = 0; pb = 0; first = 0; low = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            exp_q.delete();
            end_q.delete();
            pv = 0; pb = 0; first = 0; low = 0;
         end else begin
            if (busy && !pb) first = 1;
            if (move_valid) begin
               if (!pv) begin
                  if (exp_q.size() == 0) begin
                     chk("unexpected move", 1, 0);
                  end else begin
                     e = exp_q.pop_front();
                     chk("move_code", int'(move_code), e);
                  end
                  if (first) chk("start to move_valid", cyc - start_cyc, 3);
                  else       chk("valid low gap", low, int'(GAP) + 2);
                  first = 0;
               end
               low = 0;
            end else begin
               low++;
            end
            if (!busy && pb) begin
               if (end_q.size() == 0) begin
                  chk("unexpected end", 1, 0);
               end else begin
                  r = end_q.pop_front();
                  chk("end done",       int'(done), r.done_v);
                  chk("end overrun",    int'(overrun), r.ovr);
                  chk("end move_count", int'(move_count), r.cnt);
                  chk("end dmem_addr",  int'(dmem_addr), r.addr);
                  chk("end move_valid", int'(move_valid), 0);
                  if (r.rel >= 0) chk("end latency", cyc - start_cyc, r.rel);
               end
            end
            pv = move_valid;
            pb = busy;
         end
      end
   end

   initial begin : driver
      int budget;
      bit seen;
      logic [DW-1:0] v;
      int k;
      rst = 1'b0;
      start = 1'b0;
      for (int i = 0; i < (1 << AW); i++) mem[AW'(i)] = '0;
      #3;
      chk_reset("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Two moves then END_CODE; upper data bits carry junk.
      mem = '{32'hABCD_0000, 32'h1234_5671, 32'h0000_00FF, 32'h0};
      done_delay = 5;
      run_seq(0, -1, 0);

      // Empty list: DONE three cycles after start.
      mem[0] = 32'h5A5A_A5AF;
      run_seq(0, 3, 0);

      // No END_CODE: all four entries issued, then overrun; start noise while busy.
      mem = '{32'h0000_00F0, 32'h0000_00F0, 32'h0000_00F0, 32'h0000_00F0};
      done_delay = 0;
      run_seq(0, -1, 1);

      // Abort together with the second move_done, then a clean restart.
      mem = '{32'h0, 32'h1, 32'h2, 32'h3};
      done_delay = 2;
      run_seq(2, -1, 0);
      run_seq(0, -1, 0);

      // Asynchronous reset while in GAP.
      mem = '{32'h3, 32'h5, 32'hF, 32'h0};
      done_delay = 1;
      abort_at = 0;
      push_model(0, -1);
      pulse_start();
      budget = 100;
      seen = 0;
      while (budget > 0 && !(seen && !move_valid)) begin
         if (move_valid) seen = 1;
         @(posedge clk); #1;
         budget--;
      end
      if (budget == 0) chk("gap entry timeout", 1, 0);
      @(posedge clk); #1;
      chk("gap busy", int'(busy), 1);
      chk("gap move_valid", int'(move_valid), 0);
      chk("gap move_count", int'(move_count), 1);
      #2 rst = 1'b0;
      #1 chk_reset("async reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      chk("idle after reset", int'(busy), 0);

      // Randomized lists, acknowledge delays, aborts and start noise.
      done_delay = -1;
      for (int s = 0; s < 30; s++) begin
         for (int i = 0; i < (1 << AW); i++) begin
            v = $urandom();
            if ($urandom_range(0, 3) == 0) v[MW-1:0] = ENDC;
            else                           v[MW-1:0] = MW'($urandom_range(0, 14));
            mem[AW'(i)] = v;
         end
         k = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
         run_seq(k, -1, 1);
      end

      repeat (3) @(posedge clk);
      chk("leftover moves", exp_q.size(), 0);
      chk("leftover ends", end_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
Upstream feeder for the servo move translator. On start, it walks the move list stored in data memory one entry at a time, starting at START_ADDR. Each 4-bit move code is presented to the translator, held until the translator reports completion, and followed by a programmable settle gap before the next fetch. The sequence ends on END_CODE, on address exhaustion, or on abort.

Parameters:
ADDR_WIDTH, 8, width of the dmem address; the maximum list length is 2^ADDR_WIDTH entries.
MOVE_WIDTH, 4, width of a move code, taken from the low bits of dmem_rdata.
DATA_WIDTH, 32, width of the dmem read data.
START_ADDR, 0, first dmem address of the move list.
END_CODE, 4'hF, move code that terminates the sequence; it is never issued.
GAP_CYCLES, 50000000, idle clk cycles between moves (1 s at 50 MHz); 0 means no gap.

Ports:
clk  in  1  system clock.
rst  in  1  reset, asynchronous, active-low.
start  in  1  one-cycle pulse; begins a sequence from IDLE or DONE.
abort  in  1  synchronous stop; returns to IDLE.
dmem_addr  out  ADDR_WIDTH  registered read address.
dmem_rdata  in  DATA_WIDTH  dmem data, valid 1 cycle after dmem_addr.
move_code  out  MOVE_WIDTH  current move for the translator.
move_valid  out  1  move_code is valid; held until move_done.
move_done  in  1  translator completion pulse.
busy  out  1  high in every state except IDLE and DONE.
done  out  1  high while in DONE.
overrun  out  1  sequence hit the last address without END_CODE.
move_count  out  ADDR_WIDTH+1  number of moves completed in this sequence.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; dmem_addr=START_ADDR; move_code=0; move_valid=0; busy=0; done=0; overrun=0; move_count=0; gap counter=0.
- All outputs are registered.

States:
- IDLE: on start, set dmem_addr=START_ADDR, clear move_count and overrun, go FETCH.
- FETCH: dmem_addr is stable for one cycle, then go LATCH.
- LATCH: sample dmem_rdata[MOVE_WIDTH-1:0].
  - If it equals END_CODE, go DONE.
  - Otherwise load move_code, set move_valid=1, go ISSUE.
- ISSUE: hold move_code and move_valid stable until move_done=1. On that cycle:
  - clear move_valid;
  - increment move_count.
  - If dmem_addr is all-ones, set overrun=1 and go DONE; the address never wraps.
  - Otherwise increment dmem_addr, then:
    - if GAP_CYCLES=0, go FETCH;
    - else load the gap counter with GAP_CYCLES-1 and go GAP.
- GAP: decrement the gap counter each cycle; when it reaches 0, go FETCH.
- DONE: done=1. All outputs hold their values. start restarts the sequence as in IDLE.

Latency:
- start to move_valid: 3 cycles (IDLE->FETCH->LATCH->ISSUE).
- move_done to the next move_valid: GAP_CYCLES+2 cycles.

Boundary and priority rules:
- abort has top priority in every state. The next cycle is IDLE with move_valid=0, busy=0, done=0, and move_count not incremented, even if move_done arrives in the same cycle.
- start is ignored while busy.
- move_done is ignored outside ISSUE.
- Reset mid-sequence behaves exactly as the reset state above.
- move_count saturates at 2^ADDR_WIDTH.
- dmem_rdata bits above MOVE_WIDTH are ignored.

Decomposition:
- Shared package servo_pkg holds:
  - move-code constants (MOVE_L=4'h0, MOVE_LP=4'h1, and the remaining faces/primes, END_CODE=4'hF);
  - the sequencer state encoding;
  - the default GAP_CYCLES constant. The translator uses the same constant for its 1 s step timer.
- One sub-module, gap_timer: a loadable down-counter with load, value and zero outputs, reusable by the translator.

Test Plan:
- dmem = {0,1,F}, GAP_CYCLES=4, pulse start, move_done 5 cycles after each move_valid -> move_code 0 then 1 issued; move_count ends at 2; done=1; busy=0; dmem_addr ends at 2.
- Timing check: start -> move_valid exactly 3 cycles later; after move_done, move_valid low for 4+2 cycles before the next move.
- dmem[0]=F -> no move_valid ever; done=1 at cycle 3; move_count=0.
- ADDR_WIDTH=2, dmem={0,0,0,0} with no END_CODE -> 4 moves issued; overrun=1; done=1; dmem_addr stays at 3.
- abort asserted in the same cycle as move_done on move 2 -> IDLE next cycle; move_valid=0; move_count=1. A following start restarts at START_ADDR with move_count=0.
- rst driven low while in GAP -> all outputs at reset values immediately (asynchronous). start pulses during ISSUE are ignored, with no change in sequence.
